// File: rtl/eth_pcs_rx_block_sync.sv
// ============================================================================
//  Module      : eth_pcs_rx_block_sync
//  Description : 64b/66b receive block lock FSM. It qualifies sync headers and
//                requests gearbox bit slips until lock is reached and held.
//                Optional macro PCS_BLOCK_SYNC_SLIP_HOLD_EN discards two headers
//                after every slip while the gearbox settles.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module eth_pcs_rx_block_sync #(
    parameter int SH_TH       = 64,
    parameter int SH_INVAL_TH = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sh_valid,
    input  logic [1:0] i_sync,
    output logic       o_slip,
    output logic       o_block_lock
);

    localparam int W_SH_TH       = $clog2(SH_TH);
    localparam int W_SH_INVAL_TH = $clog2(SH_INVAL_TH);
    localparam int CW            = W_SH_TH + 1;
    localparam int IW            = W_SH_INVAL_TH + 1;

    localparam logic [CW-1:0] SH_TH_C       = CW'(SH_TH);
    localparam logic [IW-1:0] SH_INVAL_TH_C = IW'(SH_INVAL_TH);

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    localparam logic [1:0] LOCK_INIT = 2'd0;
    localparam logic [1:0] TEST      = 2'd1;
    localparam logic [1:0] SLIP      = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [CW-1:0] sh_cnt;
    logic [CW-1:0] sh_cnt_next;
    logic [IW-1:0] sh_inval_cnt;
    logic [IW-1:0] sh_inval_cnt_next;
    logic          slip_next;
    logic          lock_next;
    logic          holding;

    logic          hdr_ok;
    logic          eval;
    logic [CW-1:0] sh_cnt_inc;
    logic [IW-1:0] sh_inval_inc;
    logic          win_end;
    logic          go_slip;

    assign hdr_ok       = (i_sync == SYNC_DATA) || (i_sync == SYNC_CTRL);
    assign eval         = (state == TEST) && i_sh_valid && !holding;
    assign sh_cnt_inc   = sh_cnt + 1'b1;
    assign sh_inval_inc = sh_inval_cnt + {{W_SH_INVAL_TH{1'b0}}, ~hdr_ok};
    assign win_end      = (sh_cnt_inc == SH_TH_C);
    // Lock loss outranks a window end landing on the same header.
    assign go_slip      = eval && (o_block_lock ? (sh_inval_inc == SH_INVAL_TH_C) : !hdr_ok);

`ifdef PCS_BLOCK_SYNC_SLIP_HOLD_EN
    logic [1:0] hold_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_cnt <= 2'd0;
        end else if (state == SLIP) begin
            hold_cnt <= 2'd2;
        end else if ((state == TEST) && i_sh_valid && (hold_cnt != 2'd0)) begin
            hold_cnt <= hold_cnt - 2'd1;
        end
    end

    assign holding = (hold_cnt != 2'd0);
`else
    assign holding = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= LOCK_INIT;
            sh_cnt       <= '0;
            sh_inval_cnt <= '0;
            o_slip       <= 1'b0;
            o_block_lock <= 1'b0;
        end else begin
            state        <= state_next;
            sh_cnt       <= sh_cnt_next;
            sh_inval_cnt <= sh_inval_cnt_next;
            o_slip       <= slip_next;
            o_block_lock <= lock_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOCK_INIT: state_next = TEST;
            TEST:      state_next = go_slip ? SLIP : TEST;
            SLIP:      state_next = TEST;
            default:   state_next = LOCK_INIT;
        endcase
    end

    always_comb begin
        sh_cnt_next       = sh_cnt;
        sh_inval_cnt_next = sh_inval_cnt;
        slip_next         = 1'b0;
        lock_next         = o_block_lock;
        case (state)
            LOCK_INIT: begin
                sh_cnt_next       = '0;
                sh_inval_cnt_next = '0;
                lock_next         = 1'b0;
            end
            TEST: begin
                if (eval) begin
                    if (go_slip) begin
                        sh_cnt_next       = '0;
                        sh_inval_cnt_next = '0;
                        slip_next         = 1'b1;
                        lock_next         = 1'b0;
                    end else if (win_end) begin
                        sh_cnt_next       = '0;
                        sh_inval_cnt_next = '0;
                        lock_next         = 1'b1;
                    end else begin
                        sh_cnt_next       = sh_cnt_inc;
                        sh_inval_cnt_next = sh_inval_inc;
                    end
                end
            end
            SLIP: begin
                sh_cnt_next       = '0;
                sh_inval_cnt_next = '0;
            end
            default: begin
                sh_cnt_next       = '0;
                sh_inval_cnt_next = '0;
                lock_next         = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: doc/eth_pcs_rx_block_sync.md
ETH_PCS_RX_BLOCK_SYNC -- requirements
Module: eth_pcs_rx_block_sync

Interface
REQ-001 SHALL have parameter SH_TH, default 64 (package value), meaning headers per test window.
REQ-002 SHALL have parameter SH_INVAL_TH, default 16 (package value), meaning invalid headers per window that drop lock.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_sh_valid  input  1  i_sync carries a block's sync header this cycle.
REQ-006 SHALL have port i_sync  input  W_SYNC  received sync header, already bit-reversed to transmit order.
REQ-007 SHALL have port o_slip  output  1  one-cycle request to the RX gearbox to shift alignment by one bit.
REQ-008 SHALL have port o_block_lock  output  1  block lock achieved.

Function
REQ-009 SHALL classify a header as valid iff i_sync equals SYNC_DATA (2'b10) or SYNC_CTRL (2'b01); 2'b00 and 2'b11 are invalid.
REQ-010 SHALL implement FSM states LOCK_INIT, TEST, SLIP; reset state LOCK_INIT.
REQ-011 SHALL keep sh_cnt (W_SH_TH+1 bits) and sh_inval_cnt (W_SH_INVAL_TH+1 bits), both counting only cycles with i_sh_valid=1.
REQ-012 LOCK_INIT: clear both counters, o_block_lock=0; next cycle go to TEST unconditionally.
REQ-013 TEST, unlocked, invalid header: assert o_slip the next cycle, clear counters, go to SLIP.
REQ-014 TEST, unlocked, 64th consecutive valid header: set o_block_lock the next cycle, clear counters, stay in TEST.
REQ-015 TEST, locked: each invalid header increments sh_inval_cnt; reaching SH_INVAL_TH SHALL clear o_block_lock, assert o_slip and enter SLIP on the next cycle, even before the window ends.
REQ-016 TEST, locked, window of SH_TH headers completes with sh_inval_cnt < SH_INVAL_TH: clear both counters, keep lock.
REQ-017 Simultaneous window end and 16th invalid header SHALL be treated as lock loss (REQ-015 wins).
REQ-018 SLIP: o_slip is high for exactly one cycle; headers arriving while o_slip=1 SHALL be ignored; next cycle return to TEST with counters cleared.
REQ-019 o_slip SHALL never be high on two consecutive cycles.
REQ-020 o_slip and o_block_lock SHALL be registered outputs; latency from deciding header to output change is one cycle.
REQ-021 Counters SHALL never wrap; they clear at window end before overflow.
REQ-022 Cycles with i_sh_valid=0 SHALL hold all state and counters unchanged (except SLIP->TEST transition).

Reset
REQ-023 On i_rst=1, asynchronously: state=LOCK_INIT, counters=0, o_slip=0, o_block_lock=0.
REQ-024 Reset asserted mid-window or during SLIP SHALL abort immediately; no residual slip pulse after release.
REQ-025 First header evaluation SHALL occur no earlier than the second clock edge after reset release.

Configuration
REQ-026 Macro PCS_BLOCK_SYNC_SLIP_HOLD_EN: when defined, after each slip the block SHALL discard the next 2 i_sh_valid headers (gearbox settling) before evaluating headers in TEST.
REQ-027 When PCS_BLOCK_SYNC_SLIP_HOLD_EN is undefined, evaluation SHALL resume on the first i_sh_valid after SLIP exits.

Verification
REQ-028 Reset release, 64 headers of 2'b01/2'b10 at i_sh_valid every cycle -> o_block_lock=1 exactly one cycle after 64th header, o_slip never high.
REQ-029 Unlocked, 10 valid then 1 header 2'b11 -> o_slip=1 for one cycle, o_block_lock=0, sh_cnt restarts; 64 further valid headers -> lock.
REQ-030 Locked, 15 invalid headers spread in a 64-header window -> lock held; next window 16 invalid -> lock drops and o_slip pulses the cycle after 16th.
REQ-031 Locked, 16th invalid header coincides with 64th header of window -> o_block_lock=0, o_slip=1 (REQ-017).
REQ-032 i_rst pulsed during SLIP and mid-window, plus i_sh_valid gapped 1-of-3 cycles -> all outputs 0 after reset, lock after 64 valid headers regardless of gaps.
REQ-033 With PCS_BLOCK_SYNC_SLIP_HOLD_EN defined: slip, then 2 invalid headers, then 64 valid -> no second slip, lock after 66th post-slip header; undefined -> second slip occurs.
